data_mem_hs: RTL and testbench

- Byte-addressed, parametrised data memory for the single-cycle/multicycle CPU datapath.
- Successor to the fixed 128x32 word memory. Adds:
  - byte/half/word loads and stores, with sign or zero extension on loads
  - alignment and range error reporting
  - valid/ready request and response handshakes with configurable latency
  - a reset-triggered clear sweep
- Sits between the core's load/store unit and the word array.

---
 rtl/data_mem_pkg.sv | 62 ++++++
 rtl/mem_lane_array.sv | 27 ++
 rtl/data_mem_hs.sv | 151 +++++++++++++++
 tb/tb_data_mem_hs.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings, FSM states and lane helpers for the byte-addressed data memory.
package data_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Fields captured at accept time and needed to shape the response.
    typedef struct packed {
        logic       load;
        logic       err;
        logic       uns;
        logic [1:0] size;
        logic [1:0] off;
    } req_info_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low-order store data so every enabled lane sees its byte.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_B:    lanes = {4{wdata[7:0]}};
            SZ_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    res = {{24{~uns & b[7]}}, b};
            SZ_H:    res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_array.sv
// DEPTH x 4 byte-lane storage: byte-enable write port and registered read; contents are not reset.
module mem_lane_array #(
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][i] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with valid/ready request/response handshakes,
// configurable response latency and a clear sweep after every reset.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    req_info_t        info;

    logic             accept;
    logic             req_err;
    logic [1:0]       req_off;
    logic [IDX_W-1:0] req_idx;

    logic             arr_we;
    logic [3:0]       arr_be;
    logic [IDX_W-1:0] arr_waddr;
    logic [31:0]      arr_wdata;
    logic             arr_re;
    logic [31:0]      arr_rdata;

    assign accept  = req_valid && req_ready;
    assign req_off = req_addr[1:0];
    assign req_idx = req_addr[IDX_W+1:2];

    // Illegal size, misalignment, or a word index past the end of the array.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = req_off[0];
            SZ_W:    req_err = |req_off;
            default: req_err = 1'b1;
        endcase
        if ((req_addr >> 2) >= ADDR_W'(DEPTH)) req_err = 1'b1;
    end

    // The sweep owns the write port in CLEAR; otherwise only a clean accepted request touches the array.
    always_comb begin
        arr_we    = 1'b0;
        arr_be    = 4'b1111;
        arr_waddr = idx;
        arr_wdata = 32'd0;
        arr_re    = 1'b0;
        if (state == ST_CLEAR) begin
            arr_we = 1'b1;
        end else if (accept && !req_err) begin
            arr_we    = req_we;
            arr_re    = !req_we;
            arr_be    = byte_en(req_size, req_off);
            arr_waddr = req_idx;
            arr_wdata = store_lanes(req_size, req_wdata);
        end
    end

    mem_lane_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (req_idx),
        .rdata (arr_rdata)
    );

    // The array read register holds the word for the whole response; decode is gated by rsp_valid.
    assign rsp_rdata = (rsp_valid && info.load) ?
                       load_extract(arr_rdata, info.size, info.off, info.uns) : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            idx       <= '0;
            cnt       <= '0;
            info      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        init_busy <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        info      <= '{load: !req_we && !req_err, err: req_err,
                                       uns: req_unsigned, size: req_size, off: req_off};
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= info.err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: one instance at LATENCY=1 and one at LATENCY=4,
// checked against a byte-array reference model.
module tb_data_mem_hs;

    localparam int unsigned DEPTH = 128;
    localparam int          LAT0  = 1;
    localparam int          LAT1  = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];
    logic        init_busy [2];

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [7:0]  mem_m [2][DEPTH*4];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rr_mode [2];
    int          acc_cyc [2];
    logic        pv [2];
    logic        pr [2];
    logic [31:0] pdata [2];
    logic        perr [2];

    always #5 clk = ~clk;

    data_mem_hs #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .init_busy(init_busy[0])
    );

    data_mem_hs #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .init_busy(init_busy[1])
    );

    task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Reference behaviour: little-endian byte array, errors never touch memory.
    task automatic model_op(input int d, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] data, output logic err);
        int unsigned nb;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v    = 32'd0;
        data = 32'd0;
        err  = (sz == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
        if (err) return;
        for (int i = 0; i < int'(nb); i++) begin
            if (we) mem_m[d][addr + 32'(i)] = wd[8*i +: 8];
            else    v = v | (32'(mem_m[d][addr + 32'(i)]) << (8*i));
        end
        if (!we) begin
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            data = v;
        end
    endtask

    // Drive one request, wait for its accept, then record the expected response.
    task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic use_x, input logic [31:0] xd, input logic xe,
                         input int id, output time tacc);
        int n;
        exp_t e;
        logic [31:0] md;
        logic me;
        n = 0;
        tacc = 0;
        req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
        req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[d] && n < 2000);
        if (!req_ready[d]) begin
            chk(1'b0, $sformatf("accept_timeout d%0d id%0d", d, id), 32'(n), 32'd0);
            req_valid[d] = 1'b0;
            return;
        end
        tacc = $time;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        model_op(d, we, sz, uns, addr, wd, md, me);
        e.data = use_x ? xd : md;
        e.err  = use_x ? xe : me;
        e.id   = id;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_drain(input int d);
        int k;
        k = 0;
        while (qsize(d) != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(qsize(d) == 0, $sformatf("drain d%0d", d), 32'(qsize(d)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Hold reset 3 cycles, then measure the clear sweep on both instances.
    task automatic do_reset();
        int n0, n1, k;
        logic rdy_bad;
        n0 = 0; n1 = 0; k = 0; rdy_bad = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            for (int i = 0; i < int'(DEPTH*4); i++) mem_m[d][i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        while ((init_busy[0] || init_busy[1]) && k < 1000) begin
            @(negedge clk);
            k++;
            if (init_busy[0]) n0++;
            if (init_busy[1]) n1++;
            if ((init_busy[0] && req_ready[0]) || (init_busy[1] && req_ready[1])) rdy_bad = 1'b1;
        end
        chk(n0 == int'(DEPTH), "sweep_cycles d0", 32'(n0), 32'(DEPTH));
        chk(n1 == int'(DEPTH), "sweep_cycles d1", 32'(n1), 32'(DEPTH));
        chk(!rdy_bad, "ready_during_sweep", 32'(rdy_bad), 32'd0);
        chk(req_ready[0] && req_ready[1], "ready_after_sweep",
            32'({req_ready[0], req_ready[1]}), 32'h3);
        @(posedge clk);
        #1;
    endtask

    // Response-ready driver: random, forced low, or forced high per instance.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            rsp_ready[d] = (rr_mode[d] == 0) ? ($urandom_range(0, 2) != 0) : (rr_mode[d] == 2);
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each response handshake.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk(!req_ready[d] && !rsp_valid[d] && !rsp_err[d] && init_busy[d],
                    $sformatf("reset_ctrl d%0d", d),
                    32'({req_ready[d], rsp_valid[d], rsp_err[d], init_busy[d]}), 32'h1);
                chk(rsp_rdata[d] == 32'd0, $sformatf("reset_rdata d%0d", d), rsp_rdata[d], 32'd0);
                pv[d] = 1'b0;
                pr[d] = 1'b0;
            end else begin
                if (pv[d] && !pr[d])
                    chk(rsp_valid[d] && rsp_rdata[d] == pdata[d] && rsp_err[d] == perr[d],
                        $sformatf("hold_stable d%0d", d), rsp_rdata[d], pdata[d]);
                if (pv[d] && pr[d])
                    chk(!rsp_valid[d] && req_ready[d] && !rsp_err[d] && rsp_rdata[d] == 32'd0,
                        $sformatf("after_handshake d%0d", d),
                        32'({rsp_valid[d], req_ready[d], rsp_err[d]}), 32'h2);
                if (rsp_valid[d]) begin
                    chk(!req_ready[d], $sformatf("ready_in_resp d%0d", d), 32'(req_ready[d]), 32'd0);
                    if (!pv[d]) begin
                        chk((cyc - acc_cyc[d]) == ((d == 0) ? LAT0 : LAT1), $sformatf("latency d%0d", d),
                            32'(cyc - acc_cyc[d]), 32'((d == 0) ? LAT0 : LAT1));
                        chk(qsize(d) > 0, $sformatf("rsp_without_req d%0d", d), 32'(qsize(d)), 32'd1);
                    end
                    if (rsp_ready[d] && qsize(d) > 0) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk(rsp_rdata[d] == e.data, $sformatf("rdata d%0d id%0d", d, e.id), rsp_rdata[d], e.data);
                        chk(rsp_err[d] == e.err, $sformatf("err d%0d id%0d", d, e.id), 32'(rsp_err[d]), 32'(e.err));
                    end
                end
                if (req_valid[d] && req_ready[d]) acc_cyc[d] = cyc;
                pv[d]    = rsp_valid[d];
                pr[d]    = rsp_ready[d];
                pdata[d] = rsp_rdata[d];
                perr[d]  = rsp_err[d];
            end
        end
    end

    task automatic rand_run(input int d, input int n);
        time t;
        logic we;
        logic [1:0] sz;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, DEPTH*4 + 63))
                                               : 32'($urandom_range(0, 31));
            issue(d, we, sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, 32'd0, 1'b0, 1000 + i, t);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    time t0, t1, t2, t3;
    int  k;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
            rr_mode[d] = 2; acc_cyc[d] = 0; pv[d] = 1'b0; pr[d] = 1'b0;
        end
        do_reset();

        // Freshly cleared memory reads zero.
        issue(0, 1'b0, 2'd2, 1'b0, 32'h7C, 32'd0, 1'b1, 32'h0000_0000, 1'b0, 1, t0);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h7C, 32'd0, 1'b1, 32'h0000_0000, 1'b0, 1, t0);

        // Sub-word stores and extended loads.
        issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 2, t0);
        issue(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF9A, 1'b1, 32'd0, 1'b0, 3, t0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h1234_9A78, 1'b0, 4, t0);
        issue(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 1'b1, 32'hFFFF_FF9A, 1'b0, 5, t0);
        issue(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 1'b1, 32'h0000_009A, 1'b0, 6, t0);
        issue(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 1'b1, 32'h0000_1234, 1'b0, 7, t0);

        // Error cases leave memory untouched.
        issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0, 8, t0);
        issue(0, 1'b0, 2'd1, 1'b0, 32'h21, 32'd0, 1'b1, 32'd0, 1'b1, 9, t0);
        issue(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'h1111_1111, 1'b1, 32'd0, 1'b1, 10, t0);
        issue(0, 1'b1, 2'd3, 1'b0, 32'h20, 32'h2222_2222, 1'b1, 32'd0, 1'b1, 11, t0);
        issue(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h3333_3333, 1'b1, 32'd0, 1'b1, 12, t0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 13, t0);
        wait_drain(0);

        // Backpressure: response held for 5 cycles before release.
        rr_mode[0] = 1;
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h1234_9A78, 1'b0, 14, t0);
        k = 0;
        while (!rsp_valid[0] && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk(rsp_valid[0], "bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rr_mode[0] = 2;
        wait_drain(0);

        // Latency 4: back-to-back throughput of one per LATENCY+1 cycles.
        issue(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5_5A5A, 1'b1, 32'd0, 1'b0, 20, t0);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, 32'hA5A5_5A5A, 1'b0, 21, t1);
        issue(1, 1'b0, 2'd0, 1'b0, 32'h43, 32'd0, 1'b1, 32'hFFFF_FFA5, 1'b0, 22, t2);
        issue(1, 1'b0, 2'd1, 1'b1, 32'h40, 32'd0, 1'b1, 32'h0000_5A5A, 1'b0, 23, t3);
        chk((t1 - t0) == 50, "throughput 0-1", 32'(t1 - t0), 32'd50);
        chk((t2 - t1) == 50, "throughput 1-2", 32'(t2 - t1), 32'd50);
        chk((t3 - t2) == 50, "throughput 2-3", 32'(t3 - t2), 32'd50);
        wait_drain(1);

        // Reset while a load waits: response dropped, memory cleared again.
        issue(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 30, t0);
        wait_drain(1);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h1234_5678, 1'b0, 31, t0);
        @(posedge clk);
        #1;
        do_reset();
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h0000_0000, 1'b0, 32, t0);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h0000_0000, 1'b0, 33, t0);
        wait_drain(0);
        wait_drain(1);

        // Random traffic against the reference model.
        rr_mode[0] = 0;
        rr_mode[1] = 0;
        fork
            rand_run(0, 150);
            rand_run(1, 100);
        join
        wait_drain(0);
        wait_drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
